// File: rtl/execute_alu_pkg.sv
// Shared defines for the execute stage: opcodes, condition codes, NZCV bit
// positions and the shifter's shift-type encodings.
package execute_alu_pkg;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] SHIFT_LSL = 2'd0;
  localparam logic [1:0] SHIFT_LSR = 2'd1;
  localparam logic [1:0] SHIFT_ASR = 2'd2;
  localparam logic [1:0] SHIFT_ROR = 2'd3;

  // TST/TEQ/CMP/CMN: flag-only ops that never write rd
  function automatic logic is_test_op(input logic [3:0] opcode);
    return (opcode[3:2] == 2'b10);
  endfunction

endpackage

// File: rtl/execute_alu_cond_check.sv
// ARM condition evaluation against the current NZCV register.
module cond_check
  import execute_alu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n_s, z_s, c_s, v_s;

  assign n_s = flags[FLAG_N];
  assign z_s = flags[FLAG_Z];
  assign c_s = flags[FLAG_C];
  assign v_s = flags[FLAG_V];

  // Decode the condition field into a pass/fail decision
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z_s;
      COND_NE: pass = !z_s;
      COND_CS: pass = c_s;
      COND_CC: pass = !c_s;
      COND_MI: pass = n_s;
      COND_PL: pass = !n_s;
      COND_VS: pass = v_s;
      COND_VC: pass = !v_s;
      COND_HI: pass = c_s && !z_s;
      COND_LS: pass = !c_s || z_s;
      COND_GE: pass = (n_s == v_s);
      COND_LT: pass = (n_s != v_s);
      COND_GT: pass = !z_s && (n_s == v_s);
      COND_LE: pass = z_s || (n_s != v_s);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/execute_alu.sv
// Data-processing execute stage: 33-bit adder, logic unit, NZCV register and
// a one-deep valid/ready result buffer toward writeback.
module execute_alu
  import execute_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       cond,
  input  logic [3:0]       opcode,
  input  logic             setflags,
  input  logic [3:0]       rd,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       shflags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_rd,
  output logic             out_we,
  output logic [3:0]       flags
);

  logic             out_valid_r;
  logic [WIDTH-1:0] out_result_r;
  logic [3:0]       out_rd_r;
  logic             out_we_r;
  logic [3:0]       flags_r;

  logic             pass_s;
  logic             accept_s;
  logic             arith_s;
  logic             sub_s;
  logic             cin_s;
  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;
  logic [WIDTH-1:0] bx_s;
  logic [WIDTH:0]   sum_s;
  logic             ovf_s;
  logic [WIDTH-1:0] logic_res_s;
  logic [WIDTH-1:0] result_s;
  logic [3:0]       next_flags_s;
  logic             update_flags_s;
  logic             unused_shflags_s;

  // Only the shifter carry feeds the ALU
  assign unused_shflags_s = ^{shflags[3:2], shflags[0]};

  cond_check u_cond_check (
    .cond  (cond),
    .flags (flags_r),
    .pass  (pass_s)
  );

  assign in_ready = !out_valid_r || out_ready;
  assign accept_s = in_valid && in_ready;

  // Adder operand routing: swap for reverse ops, invert b for subtraction
  always_comb begin
    a_s     = op1;
    b_s     = op2;
    sub_s   = 1'b0;
    cin_s   = 1'b0;
    arith_s = 1'b1;
    case (opcode)
      OP_SUB, OP_CMP: begin
        sub_s = 1'b1;
        cin_s = 1'b1;
      end
      OP_RSB: begin
        a_s   = op2;
        b_s   = op1;
        sub_s = 1'b1;
        cin_s = 1'b1;
      end
      OP_ADD, OP_CMN: cin_s = 1'b0;
      OP_ADC: cin_s = flags_r[FLAG_C];
      OP_SBC: begin
        sub_s = 1'b1;
        cin_s = flags_r[FLAG_C];
      end
      OP_RSC: begin
        a_s   = op2;
        b_s   = op1;
        sub_s = 1'b1;
        cin_s = flags_r[FLAG_C];
      end
      default: arith_s = 1'b0;
    endcase
  end

  assign bx_s  = sub_s ? ~b_s : b_s;
  assign sum_s = {1'b0, a_s} + {1'b0, bx_s} + {{WIDTH{1'b0}}, cin_s};
  assign ovf_s = (a_s[WIDTH-1] == bx_s[WIDTH-1]) && (sum_s[WIDTH-1] != a_s[WIDTH-1]);

  // Logic unit; arithmetic opcodes fall to the default and are never selected
  always_comb begin
    logic_res_s = {WIDTH{1'b0}};
    case (opcode)
      OP_AND, OP_TST: logic_res_s = op1 & op2;
      OP_EOR, OP_TEQ: logic_res_s = op1 ^ op2;
      OP_ORR:         logic_res_s = op1 | op2;
      OP_MOV:         logic_res_s = op2;
      OP_BIC:         logic_res_s = op1 & ~op2;
      OP_MVN:         logic_res_s = ~op2;
      default:        logic_res_s = {WIDTH{1'b0}};
    endcase
  end

  assign result_s = arith_s ? sum_s[WIDTH-1:0] : logic_res_s;

  // Candidate NZCV; logical ops take C from the shifter and keep V
  always_comb begin
    next_flags_s         = flags_r;
    next_flags_s[FLAG_N] = result_s[WIDTH-1];
    next_flags_s[FLAG_Z] = (result_s == {WIDTH{1'b0}});
    if (arith_s) begin
      next_flags_s[FLAG_C] = sum_s[WIDTH];
      next_flags_s[FLAG_V] = ovf_s;
    end else begin
      next_flags_s[FLAG_C] = shflags[FLAG_C];
      next_flags_s[FLAG_V] = flags_r[FLAG_V];
    end
  end

  assign update_flags_s = pass_s && (setflags || is_test_op(opcode));

  // Result buffer and flag register; a failed condition still occupies a slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      out_result_r <= {WIDTH{1'b0}};
      out_rd_r     <= 4'h0;
      out_we_r     <= 1'b0;
      flags_r      <= 4'b0000;
    end else if (accept_s) begin
      out_valid_r  <= 1'b1;
      out_result_r <= pass_s ? result_s : {WIDTH{1'b0}};
      out_rd_r     <= rd;
      out_we_r     <= pass_s && !is_test_op(opcode);
      if (update_flags_s) begin
        flags_r <= next_flags_s;
      end
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_valid  = out_valid_r;
  assign out_result = out_result_r;
  assign out_rd     = out_rd_r;
  assign out_we     = out_we_r;
  assign flags      = flags_r;

endmodule

// File: tb/tb_execute_alu.sv
// Self-checking bench for execute_alu: directed scenarios plus randomized
// traffic against an arithmetic reference model.
module tb_execute_alu;
  import execute_alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  cond;
  logic [3:0]  opcode;
  logic        setflags;
  logic [3:0]  rd;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [3:0]  shflags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_rd;
  logic        out_we;
  logic [3:0]  flags;

  int n_vec;
  int n_err;

  // reference model state
  logic        m_valid;
  logic [31:0] m_result;
  logic [3:0]  m_rd;
  logic        m_we;
  logic [3:0]  m_flags;

  execute_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .cond(cond), .opcode(opcode), .setflags(setflags), .rd(rd),
    .op1(op1), .op2(op2), .shflags(shflags), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
    .out_we(out_we), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic m_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Arithmetic evaluated with wide signed/unsigned integers, not bit tricks
  function automatic void m_alu(input logic [3:0] opc, input logic [31:0] x, input logic [31:0] y,
                                input logic [3:0] f, input logic shc,
                                output logic [31:0] r, output logic [3:0] nf);
    logic [31:0] p, q;
    logic        is_sub, arith, c, v;
    longint      ci, up, uq, sp, sq, tot, st;
    p = x; q = y; is_sub = 1'b0; arith = 1'b1; ci = 0; r = 32'h0;
    case (opc)
      4'h0, 4'h8: begin r = x & y;  arith = 1'b0; end
      4'h1, 4'h9: begin r = x ^ y;  arith = 1'b0; end
      4'hC:       begin r = x | y;  arith = 1'b0; end
      4'hD:       begin r = y;      arith = 1'b0; end
      4'hE:       begin r = x & ~y; arith = 1'b0; end
      4'hF:       begin r = ~y;     arith = 1'b0; end
      4'h2, 4'hA: begin is_sub = 1'b1; ci = 1; end
      4'h3:       begin p = y; q = x; is_sub = 1'b1; ci = 1; end
      4'h4, 4'hB: ci = 0;
      4'h5:       ci = f[1] ? 1 : 0;
      4'h6:       begin is_sub = 1'b1; ci = f[1] ? 1 : 0; end
      4'h7:       begin p = y; q = x; is_sub = 1'b1; ci = f[1] ? 1 : 0; end
      default:    arith = 1'b0;
    endcase
    up = longint'(p); uq = longint'(q);
    sp = longint'($signed(p)); sq = longint'($signed(q));
    if (is_sub) begin
      tot = up - uq - (1 - ci);
      st  = sp - sq - (1 - ci);
      c   = (tot >= 0);
    end else begin
      tot = up + uq + ci;
      st  = sp + sq + ci;
      c   = (tot >= 64'sh1_0000_0000);
    end
    v = (st > 64'sd2147483647) || (st < -64'sd2147483648);
    if (arith) r = tot[31:0];
    nf = {r[31], (r == 32'h0), arith ? c : shc, arith ? v : f[0]};
  endfunction

  task automatic set_op(input logic [3:0] c, input logic [3:0] opc, input logic s,
                        input logic [3:0] d, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] shf);
    in_valid = 1'b1; cond = c; opcode = opc; setflags = s; rd = d;
    op1 = a; op2 = b; shflags = shf;
  endtask

  // One clock edge; the model follows the handshake visible at that edge
  task automatic step();
    logic [31:0] r;
    logic [3:0]  nf;
    logic        ok;
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1'b0; m_result = 32'h0; m_rd = 4'h0; m_we = 1'b0; m_flags = 4'h0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      ok = m_cond(cond, m_flags);
      m_alu(opcode, op1, op2, m_flags, shflags[1], r, nf);
      m_valid  = 1'b1;
      m_rd     = rd;
      m_we     = ok && !(opcode >= 4'h8 && opcode <= 4'hB);
      m_result = ok ? r : 32'h0;
      if (ok && (setflags || (opcode >= 4'h8 && opcode <= 4'hB))) m_flags = nf;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_op(COND_AL, OP_MOV, 1'b0, 4'h0, 32'h0, 32'h0, 4'h0);
    in_valid = 1'b0;
    step(); step();
    n_vec++;
    if ({out_valid, out_we, out_rd, out_result, flags} !== 42'h0) begin
      n_err++;
      $display("FAIL reset_state: got v=%b we=%b rd=%h res=%h flags=%b, expected all zero",
               out_valid, out_we, out_rd, out_result, flags);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_adds_overflow();
    set_op(COND_AL, OP_ADD, 1'b1, 4'h3, 32'h7FFFFFFF, 32'h1, 4'h0);
    step();
    n_vec++;
    if (out_result !== 32'h80000000) begin
      n_err++; $display("FAIL adds_result: got %h expected 80000000", out_result);
    end
    n_vec++;
    if (out_we !== 1'b1 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL adds_we: got we=%b v=%b expected 1 1", out_we, out_valid);
    end
    n_vec++;
    if (flags !== 4'b1001) begin
      n_err++; $display("FAIL adds_flags: got %b expected 1001", flags);
    end
  endtask

  task automatic test_cmp_cond();
    set_op(COND_AL, OP_CMP, 1'b0, 4'h1, 32'd5, 32'd5, 4'h0);
    step();
    n_vec++;
    if (out_we !== 1'b0 || flags !== 4'b0110) begin
      n_err++; $display("FAIL cmp_eq: got we=%b flags=%b expected 0 0110", out_we, flags);
    end
    set_op(COND_NE, OP_ADD, 1'b0, 4'h2, 32'd7, 32'd8, 4'h0);
    step();
    n_vec++;
    if ({out_valid, out_we, out_rd, out_result, flags} !== {1'b1, 1'b0, 4'h2, 32'h0, 4'b0110}) begin
      n_err++;
      $display("FAIL cond_fail: got v=%b we=%b rd=%h res=%h flags=%b expected 1 0 2 0 0110",
               out_valid, out_we, out_rd, out_result, flags);
    end
    set_op(COND_EQ, OP_ADD, 1'b0, 4'h4, 32'd2, 32'd3, 4'h0);
    step();
    n_vec++;
    if (out_result !== 32'd5 || out_we !== 1'b1) begin
      n_err++; $display("FAIL cond_pass: got res=%h we=%b expected 5 1", out_result, out_we);
    end
  endtask

  task automatic test_carry_ops();
    set_op(COND_AL, OP_ADC, 1'b1, 4'h5, 32'hFFFFFFFF, 32'h0, 4'h0);
    step();
    n_vec++;
    if (out_result !== 32'h0 || flags !== 4'b0110) begin
      n_err++; $display("FAIL adcs: got res=%h flags=%b expected 0 0110", out_result, flags);
    end
    set_op(COND_AL, OP_MOV, 1'b1, 4'h6, 32'h0, 32'h1, 4'b0000);
    step();
    n_vec++;
    if (flags !== 4'b0000) begin
      n_err++; $display("FAIL movs_clear_c: got %b expected 0000", flags);
    end
    set_op(COND_AL, OP_SBC, 1'b1, 4'h7, 32'h0, 32'h0, 4'h0);
    step();
    n_vec++;
    if (out_result !== 32'hFFFFFFFF || flags !== 4'b1000) begin
      n_err++; $display("FAIL sbcs: got res=%h flags=%b expected ffffffff 1000", out_result, flags);
    end
  endtask

  task automatic test_movs_keeps_v();
    set_op(COND_AL, OP_ADD, 1'b1, 4'h1, 32'h7FFFFFFF, 32'h1, 4'h0);
    step();
    set_op(COND_AL, OP_MOV, 1'b1, 4'h8, 32'h12345678, 32'h0, 4'b0010);
    step();
    n_vec++;
    if (out_result !== 32'h0 || flags !== 4'b0111) begin
      n_err++; $display("FAIL movs_v: got res=%h flags=%b expected 0 0111", out_result, flags);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] fsnap;
    out_ready = 1'b1;
    set_op(COND_AL, OP_ADD, 1'b0, 4'h5, 32'd10, 32'd20, 4'h0);
    step();
    fsnap = flags;
    out_ready = 1'b0;
    set_op(COND_AL, OP_SUB, 1'b1, 4'h9, 32'd1, 32'd2, 4'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if (in_ready !== 1'b0) begin
        n_err++; $display("FAIL stall_in_ready: cycle %0d got %b expected 0", i, in_ready);
      end
      step();
      n_vec++;
      if ({out_valid, out_we, out_rd, out_result, flags} !== {1'b1, 1'b1, 4'h5, 32'd30, fsnap}) begin
        n_err++;
        $display("FAIL stall_hold: cycle %0d got v=%b we=%b rd=%h res=%h flags=%b expected 1 1 5 1e %b",
                 i, out_valid, out_we, out_rd, out_result, flags, fsnap);
      end
    end
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL drain_in_ready: got %b expected 1", in_ready);
    end
    step();
    n_vec++;
    if (out_valid !== 1'b1 || out_result !== 32'hFFFFFFFF || out_rd !== 4'h9 || flags !== 4'b1000) begin
      n_err++;
      $display("FAIL drain_accept: got v=%b res=%h rd=%h flags=%b expected 1 ffffffff 9 1000",
               out_valid, out_result, out_rd, flags);
    end
    for (int i = 1; i <= 4; i++) begin
      set_op(COND_AL, OP_ADD, 1'b0, 4'(i), 32'(i * 100), 32'(i), 4'h0);
      step();
      n_vec++;
      if (out_valid !== 1'b1 || out_result !== 32'(i * 101) || out_rd !== 4'(i)) begin
        n_err++;
        $display("FAIL b2b: op %0d got v=%b res=%h rd=%h expected 1 %h %h",
                 i, out_valid, out_result, out_rd, 32'(i * 101), 4'(i));
      end
    end
  endtask

  task automatic test_reset_stall();
    out_ready = 1'b0;
    set_op(COND_AL, OP_ADD, 1'b1, 4'h3, 32'd4, 32'd4, 4'h0);
    step();
    rst_n = 1'b0;
    step();
    n_vec++;
    if ({out_valid, out_we, out_rd, out_result, flags} !== 42'h0) begin
      n_err++;
      $display("FAIL reset_stall: got v=%b we=%b rd=%h res=%h flags=%b expected all zero",
               out_valid, out_we, out_rd, out_result, flags);
    end
    rst_n = 1'b1; out_ready = 1'b1;
    set_op(COND_AL, OP_ADD, 1'b0, 4'h9, 32'd1, 32'd2, 4'h0);
    step();
    n_vec++;
    if ({out_valid, out_we, out_rd, out_result} !== {1'b1, 1'b1, 4'h9, 32'd3}) begin
      n_err++;
      $display("FAIL after_reset: got v=%b we=%b rd=%h res=%h expected 1 1 9 3",
               out_valid, out_we, out_rd, out_result);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 400; i++) begin
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 5))
        0: a = 32'h7FFFFFFF;
        1: b = 32'h80000000;
        2: b = a;
        3: a = 32'hFFFFFFFF;
        default: ;
      endcase
      set_op(($urandom_range(0, 1) == 0) ? COND_AL : 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), a, b, 4'($urandom_range(0, 15)));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_vec++;
      if (in_ready !== (!m_valid || out_ready)) begin
        n_err++; $display("FAIL rand_in_ready: iter %0d got %b expected %b", i, in_ready, !m_valid || out_ready);
      end
      step();
      n_vec++;
      if (m_valid) begin
        if ({out_valid, out_we, out_rd, out_result, flags} !== {m_valid, m_we, m_rd, m_result, m_flags}) begin
          n_err++;
          $display("FAIL rand_out: iter %0d got v=%b we=%b rd=%h res=%h flags=%b expected v=%b we=%b rd=%h res=%h flags=%b",
                   i, out_valid, out_we, out_rd, out_result, flags, m_valid, m_we, m_rd, m_result, m_flags);
        end
      end else if ({out_valid, flags} !== {1'b0, m_flags}) begin
        n_err++;
        $display("FAIL rand_idle: iter %0d got v=%b flags=%b expected 0 %b", i, out_valid, flags, m_flags);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_valid = 1'b0; m_result = 32'h0; m_rd = 4'h0; m_we = 1'b0; m_flags = 4'h0;
    test_reset();
    test_adds_overflow();
    test_cmp_cond();
    test_carry_ops();
    test_movs_keeps_v();
    test_back_to_back();
    test_reset_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
